// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: oversampling UART receive front-end.
// Two-flop synchronizer, 3-sample majority vote per bit, false-start
// rejection, even-parity and framing checks, overrun pulse and a
// valid/ready byte output feeding the receive FIFO.
// Optional break detection is built when UART_RX_BREAK_DETECT_EN is defined;
// otherwise break_o is tied low.
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | waiting for a falling edge on the synchronized line
// START     | confirming the start bit at mid-bit (false-start check)
// DATA      | collecting data bits, LSB first
// PARITY    | checking the even-parity bit
// STOP      | voting the stop bit; the frame completes at the vote
// WAIT_HIGH | line still low after the stop vote; wait for idle
module uart_rx_sampler #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 rx_i,
  input  logic                 cfg_en_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  input  logic                 cfg_parity_en_i,
  input  logic [1:0]           cfg_bits_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 err_o,
  output logic                 overrun_o,
  output logic                 break_o,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

  state_t               state, state_nxt;
  logic                 rx_meta, rxs, rxs_d;
  logic [DIV_WIDTH-1:0] div, half, cnt;
  logic                 samp_a, samp_b, vote;
  logic                 at_early, at_mid, at_vote, at_end;
  logic                 fall, complete;
  logic [2:0]           idx, last_idx;
  logic [7:0]           shreg;
  logic                 perr;
  logic [7:0]           data_q;
  logic                 valid_q, err_q, ovr_q;

  // two-flop synchronizer (idle-high reset) plus one flop of history for edge detect
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // divisor clamp, sample instants, majority vote and frame-length decode
  always_comb begin
    div      = (cfg_div_i < DIV_MIN) ? DIV_MIN : cfg_div_i;
    half     = div >> 1;
    at_early = (cnt == half - ONE);
    at_mid   = (cnt == half);
    at_vote  = (cnt == half + ONE);
    at_end   = (cnt == div);
    vote     = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
    fall     = rxs_d & ~rxs;
    last_idx = {1'b0, cfg_bits_i} + 3'd4;
    complete = cfg_en_i && (state == STOP) && at_vote;
  end

  // state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    if (!cfg_en_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (fall) state_nxt = START;
        START: begin
          if (at_vote && vote) state_nxt = IDLE;
          else if (at_end)     state_nxt = DATA;
        end
        DATA:      if (at_end && (idx == last_idx)) state_nxt = cfg_parity_en_i ? PARITY : STOP;
        PARITY:    if (at_end) state_nxt = STOP;
        STOP:      if (at_vote) state_nxt = vote ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (rxs) state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // bit-period counter and the two early majority samples
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt    <= '0;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      if (!cfg_en_i || (state == IDLE) || (state == WAIT_HIGH) || at_end) cnt <= '0;
      else cnt <= cnt + ONE;
      if (at_early) samp_a <= rxs;
      if (at_mid)   samp_b <= rxs;
    end
  end

  // frame assembly: data shift-in by index, bit index and parity result
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else if (state == IDLE) begin
      idx   <= '0;
      shreg <= '0;
      perr  <= 1'b0;
    end else begin
      if ((state == DATA) && at_vote)   shreg[idx] <= vote;
      if ((state == DATA) && at_end)    idx <= idx + 3'd1;
      if ((state == PARITY) && at_vote) perr <= (^shreg) ^ vote;
    end
  end

  // output holding register; a completed frame is dropped if the held byte is not taken
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (!cfg_en_i) begin
        valid_q <= 1'b0;
      end else if (complete) begin
        if (!valid_q || rx_ready_i) begin
          data_q  <= shreg;
          err_q   <= perr | ~vote;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && rx_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_BREAK_DETECT_EN
  logic par_bit, brk_q;

  // break: every voted bit of the frame was 0; held until the line returns high
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      par_bit <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      if (state == IDLE)                     par_bit <= 1'b0;
      else if ((state == PARITY) && at_vote) par_bit <= vote;
      if (!cfg_en_i)                                       brk_q <= 1'b0;
      else if (complete && !vote && (shreg == 8'd0) && !par_bit) brk_q <= 1'b1;
      else if ((state == WAIT_HIGH) && rxs)                brk_q <= 1'b0;
    end
  end

  assign break_o = brk_q;
`else
  assign break_o = 1'b0;
`endif

  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign err_o      = err_q;
  assign overrun_o  = ovr_q;
  assign busy_o     = (state != IDLE);

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling UART receive front-end that turns the asynchronous `rx_i` line into framed, error-tagged bytes. It sits directly upstream of the 9-bit receive FIFO in the APB UART. Its `{err_o, rx_data_o}` pair feeds the FIFO's `data_i`, and its `rx_valid_o`/`rx_ready_i` handshake connects to the FIFO's `valid_i`/`ready_o`. It adds a 2-FF synchronizer, 3-sample majority voting, false-start rejection, even-parity and framing checks, overrun reporting and optional break detection.

## Interface
Parameters:
- `DIV_WIDTH`, 16: width of the baud divisor.

Ports:
- `clk_i` — input, 1 — clock.
- `rstn_i` — input, 1 — reset; asynchronous, active-low.
- `rx_i` — input, 1 — asynchronous serial line; idle high.
- `cfg_en_i` — input, 1 — receiver enable.
- `cfg_div_i` — input, `DIV_WIDTH` — bit period is `cfg_div_i + 1` clocks; values below 4 are treated as 4.
- `cfg_parity_en_i` — input, 1 — expect an even-parity bit after the data bits.
- `cfg_bits_i` — input, 2 — data bits: 00 = 5, 01 = 6, 10 = 7, 11 = 8.
- `rx_data_o` — output, 8 — received byte, LSB-aligned; unused upper bits are 0.
- `rx_valid_o` — output, 1 — byte available.
- `rx_ready_i` — input, 1 — consumer accepts the byte.
- `err_o` — output, 1 — parity error OR framing error of the presented byte.
- `overrun_o` — output, 1 — one-cycle pulse: a frame completed while `rx_valid_o` was still high.
- `break_o` — output, 1 — break condition (see Configuration).
- `busy_o` — output, 1 — FSM not in IDLE.

## Operation
- The synchronizer is two flops on `rx_i`, both reset to 1. All logic uses the synchronized value `rxs`.
- Bit counter `cnt` runs from 0 to `div`, then wraps to 0. `half = div >> 1`.
- Within each bit, `rxs` is sampled at `cnt = half-1`, `half` and `half+1`. The majority vote becomes valid at `cnt = half+1`.
- FSM states:
  - **IDLE**: a high-to-low transition on `rxs` moves to START with `cnt = 0`.
  - **START**: if the vote is 1, this is a false start and the FSM returns to IDLE. Otherwise it continues to the end of the bit period, then goes to DATA with bit index 0.
  - **DATA**: takes the vote per bit, LSB first. After the `N`-th bit, goes to PARITY if `cfg_parity_en_i` is set, else STOP.
  - **PARITY**: `perr` is 1 when the XOR of the data bits and the parity vote is 1.
  - **STOP**: on the vote, `ferr = ~vote`. The frame completes at the vote instant; the FSM does not wait for the end of the stop bit. If the vote is 1, go to IDLE; if it is 0, go to WAIT_HIGH.
  - **WAIT_HIGH**: stays until `rxs` is 1, then goes to IDLE. This prevents a spurious start inside a low line.
- Frame completion behaviour:
  - If `rx_valid_o` is 0 (or is being accepted in that same cycle): load the data, set `err_o = perr | ferr`, set `rx_valid_o`.
  - Otherwise: drop the new frame, pulse `overrun_o`, and keep the held byte unchanged.
- The handshake is valid/ready. Transfer occurs on a cycle where `rx_valid_o & rx_ready_i`. Data and `err_o` stay stable while valid is high and not accepted.
- `cfg_en_i` low: the FSM is forced to IDLE, `cnt` is cleared and `rx_valid_o` is cleared. The synchronizer keeps running.
- Configuration inputs are sampled live. Software changes them only while `busy_o` is 0.

## Timing
- Reset values: `rx_data_o = 0`, `rx_valid_o = 0`, `err_o = 0`, `overrun_o = 0`, `break_o = 0`, `busy_o = 0`, FSM in IDLE.
- Reset asserted mid-frame aborts the frame immediately. No output is produced.
- Line-to-FSM latency is 2 clocks through the synchronizer; START is entered on the 3rd edge after the line falls.
- `rx_valid_o` rises 1 clock after the stop-bit vote cycle (`cnt = half+1` in STOP).
- Frame length is (1 + N + P + 1) × (`div` + 1) clocks. The receiver is ready for the next start edge immediately after the stop vote.
- Simultaneous completion and accept: the new byte replaces the old one with no overrun, and `rx_valid_o` stays high.

## Configuration
- Macro: `UART_RX_BREAK_DETECT_EN`.
- Defined:
  - `break_o` rises 1 clock after the STOP vote when all data bits, the parity bit (if enabled) and the stop bit voted 0.
  - `break_o` stays high until WAIT_HIGH exits, then clears.
  - The break frame is still delivered as data 0x00 with `err_o = 1`.
- Undefined: `break_o` is tied to 0 and no break logic is synthesized. All other behaviour is identical.

## Test plan
1. **Basic 8N1 byte.** Setup: `div = 15`, 8N1. Drive 0xA5 with `rx_ready_i = 1`. Expect: one `rx_valid_o` pulse with data 0xA5 and `err_o = 0`, 1 clock after the stop vote.
2. **7E1 parity error.** Setup: `div = 15`, 7 bits, parity enabled. Drive 0x35 with a wrong parity bit. Expect: data 0x35 and `err_o = 1`. Then drive correct parity; expect `err_o = 0`.
3. **False start and glitch rejection.** (a) Drive a 4-clock low glitch with `div = 15`: expect no valid and `busy_o` back to 0 within 1 bit period. (b) Inject a single-clock inverted glitch at the mid-bit of data bit 3 in a 0x00 frame: the majority vote yields 0x00.
4. **Overrun and simultaneous accept.** (a) Hold `rx_ready_i = 0` and receive 0x11 then 0x22: `rx_data_o` stays 0x11 and `overrun_o` pulses once. (b) Assert `rx_ready_i` exactly on the 0x33 completion cycle: data becomes 0x33 with no overrun.
5. **Break with `UART_RX_BREAK_DETECT_EN`.** Hold the line low for 20 bit periods. Expect: data 0x00, `err_o = 1`, `break_o` high until the line returns high. Then a following 0x5A is received correctly. Without the macro, `break_o` stays 0.
6. **Reset mid-frame.** Assert `rstn_i` during DATA. Expect: all outputs 0 immediately. After release, the next frame 0xC3 is received correctly.
